// File: rtl/display_timings_pkg.sv
// Shared video constants: 640x480@60 raster timing and the text-mode character geometry.
// The raster generator and the framebuffer logic both import this package.
package display_timings_pkg;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // 640x480@60 Hz raster, in pixels and lines
    localparam int unsigned H_RES  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_RES  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam logic        H_POL  = 1'b0;
    localparam logic        V_POL  = 1'b0;

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Character grids laid over the active area (8x8 hires cells, 16x16 lores cells)
    localparam int unsigned HIRES_COLS = 80;
    localparam int unsigned HIRES_ROWS = 60;
    localparam int unsigned LORES_COLS = 40;
    localparam int unsigned LORES_ROWS = 30;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    // Half-open window test: lo <= pos < hi, unsigned
    function automatic logic in_span(input cnt_t pos, input cnt_t lo, input cnt_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/display_timings_if.sv
// Raster position and sync bundle from the timing generator to its consumers.
interface display_timings_if;
    import display_timings_pkg::*;

    cnt_t sx;
    cnt_t sy;
    logic hsync;
    logic vsync;
    logic de;

    modport master (output sx, sy, hsync, vsync, de);
    modport slave  (input  sx, sy, hsync, vsync, de);

endinterface

// File: rtl/display_timings.sv
// VGA raster timing generator: pixel/line counters with hsync, vsync and de decoded
// from the next count, so all outputs are registers aligned to the same position.
module display_timings
    import display_timings_pkg::*;
#(
    parameter int unsigned H_RES  = display_timings_pkg::H_RES,
    parameter int unsigned H_FP   = display_timings_pkg::H_FP,
    parameter int unsigned H_SYNC = display_timings_pkg::H_SYNC,
    parameter int unsigned H_BP   = display_timings_pkg::H_BP,
    parameter int unsigned V_RES  = display_timings_pkg::V_RES,
    parameter int unsigned V_FP   = display_timings_pkg::V_FP,
    parameter int unsigned V_SYNC = display_timings_pkg::V_SYNC,
    parameter int unsigned V_BP   = display_timings_pkg::V_BP,
    parameter logic        H_POL  = display_timings_pkg::H_POL,
    parameter logic        V_POL  = display_timings_pkg::V_POL
) (
    input  logic                 clk_pix,
    input  logic                 rst,
    display_timings_if.master    timing_o
);

    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT_END  = cnt_t'(H_RES);
    localparam cnt_t V_ACT_END  = cnt_t'(V_RES);
    localparam cnt_t HS_START   = cnt_t'(H_RES + H_FP);
    localparam cnt_t HS_END     = cnt_t'(H_RES + H_FP + H_SYNC);
    localparam cnt_t VS_START   = cnt_t'(V_RES + V_FP);
    localparam cnt_t VS_END     = cnt_t'(V_RES + V_FP + V_SYNC);

    cnt_t  sx_q, sx_d;
    cnt_t  sy_q, sy_d;
    sync_t sync_q, sync_d;

    // NOTE: every variable gets a default first, so no path through this block infers a latch.
    always_comb begin
        sx_d = sx_q + 1'b1;
        sy_d = sy_q;
        if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
        end

        // Decoding the next count lets the registered syncs line up with sx/sy
        sync_d.hsync = in_span(sx_d, HS_START, HS_END) ? H_POL : ~H_POL;
        sync_d.vsync = in_span(sy_d, VS_START, VS_END) ? V_POL : ~V_POL;
        sync_d.de    = (sx_d < H_ACT_END) && (sy_d < V_ACT_END);
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            sx_q         <= H_LAST;
            sy_q         <= V_LAST;
            sync_q.hsync <= ~H_POL;
            sync_q.vsync <= ~V_POL;
            sync_q.de    <= 1'b0;
        end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            sync_q <= sync_d;
        end
    end

    assign timing_o.sx    = sx_q;
    assign timing_o.sy    = sy_q;
    assign timing_o.hsync = sync_q.hsync;
    assign timing_o.vsync = sync_q.vsync;
    assign timing_o.de    = sync_q.de;

endmodule

// File: tb/tb_display_timings.sv
// Bench for display_timings: a full-size 640x480 instance for reset and line checks,
// and a shrunken-raster instance so whole frames fit in a short run.
module tb_display_timings;

    // Full-size raster
    localparam int B_HRES = 640, B_HFP = 16, B_HSW = 96, B_HBP = 48;
    localparam int B_VRES = 480, B_VFP = 10, B_VSW = 2,  B_VBP = 33;
    // Shrunken raster: 80 x 31 = 2480 clocks per frame
    localparam int S_HRES = 64, S_HFP = 4, S_HSW = 8, S_HBP = 4;
    localparam int S_VRES = 24, S_VFP = 2, S_VSW = 2, S_VBP = 3;
    localparam int S_FRAME = (S_HRES + S_HFP + S_HSW + S_HBP) * (S_VRES + S_VFP + S_VSW + S_VBP);
    localparam int S_HTOT  = S_HRES + S_HFP + S_HSW + S_HBP;

    typedef struct {
        int sx;
        int sy;
        bit hs;
        bit vs;
        bit de;
    } exp_t;

    logic clk = 1'b0;
    logic rst_big = 1'b0;
    logic rst_sml = 1'b0;

    int k_big = 0;
    int k_sml = 0;
    int n_checks = 0;
    int n_fail = 0;

    int de_line, hs_line, vs_low, hs_in_vs, de_vblank, vs_rise;
    bit prev_vs, prev_hs;

    display_timings_if big_if ();
    display_timings_if sml_if ();

    display_timings u_big (
        .clk_pix  (clk),
        .rst      (rst_big),
        .timing_o (big_if)
    );

    display_timings #(
        .H_RES (S_HRES), .H_FP (S_HFP), .H_SYNC (S_HSW), .H_BP (S_HBP),
        .V_RES (S_VRES), .V_FP (S_VFP), .V_SYNC (S_VSW), .V_BP (S_VBP),
        .H_POL (1'b0),   .V_POL (1'b0)
    ) u_sml (
        .clk_pix  (clk),
        .rst      (rst_sml),
        .timing_o (sml_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // k = clock edges seen since reset release; k=0 means held in reset
    function automatic exp_t model(input int k, input int hres, input int hfp, input int hsw,
                                   input int hbp, input int vres, input int vfp, input int vsw,
                                   input int vbp);
        exp_t e;
        int ht, vt, p;
        ht = hres + hfp + hsw + hbp;
        vt = vres + vfp + vsw + vbp;
        if (k == 0) begin
            e.sx = ht - 1;
            e.sy = vt - 1;
            e.de = 1'b0;
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            p    = (k - 1) % (ht * vt);
            e.sx = p % ht;
            e.sy = p / ht;
            e.de = (e.sx < hres) && (e.sy < vres);
            e.hs = !((e.sx >= hres + hfp) && (e.sx < hres + hfp + hsw));
            e.vs = !((e.sy >= vres + vfp) && (e.sy < vres + vfp + vsw));
        end
        return e;
    endfunction

    task automatic cmp_big();
        exp_t e;
        e = model(k_big, B_HRES, B_HFP, B_HSW, B_HBP, B_VRES, B_VFP, B_VSW, B_VBP);
        check("big_sx", 32'(big_if.sx), 32'(e.sx));
        check("big_sy", 32'(big_if.sy), 32'(e.sy));
        check("big_hsync", 32'(big_if.hsync), 32'(e.hs));
        check("big_vsync", 32'(big_if.vsync), 32'(e.vs));
        check("big_de", 32'(big_if.de), 32'(e.de));
    endtask

    task automatic cmp_sml();
        exp_t e;
        e = model(k_sml, S_HRES, S_HFP, S_HSW, S_HBP, S_VRES, S_VFP, S_VSW, S_VBP);
        check("sml_sx", 32'(sml_if.sx), 32'(e.sx));
        check("sml_sy", 32'(sml_if.sy), 32'(e.sy));
        check("sml_hsync", 32'(sml_if.hsync), 32'(e.hs));
        check("sml_vsync", 32'(sml_if.vsync), 32'(e.vs));
        check("sml_de", 32'(sml_if.de), 32'(e.de));
    endtask

    task automatic clear_stats();
        de_line = 0; hs_line = 0; vs_low = 0; hs_in_vs = 0; de_vblank = 0; vs_rise = 0;
        prev_vs = 1'b1;
        prev_hs = 1'b1;
    endtask

    // One clock: advance both models on the edge, compare both DUTs on the falling edge
    task automatic tick();
        @(posedge clk);
        k_big = rst_big ? k_big + 1 : 0;
        k_sml = rst_sml ? k_sml + 1 : 0;
        @(negedge clk);
        cmp_big();
        cmp_sml();
        if (k_big > 0 && big_if.sy == 10'd0) begin
            if (big_if.de) de_line++;
            if (!big_if.hsync) hs_line++;
        end
        if (!sml_if.vsync) begin
            vs_low++;
            if (prev_hs && !sml_if.hsync) hs_in_vs++;
        end
        if (sml_if.sy >= 10'(S_VRES) && sml_if.de) de_vblank++;
        if (!prev_vs && sml_if.vsync) vs_rise++;
        prev_vs = sml_if.vsync;
        prev_hs = sml_if.hsync;
    endtask

    task automatic async_reset_big();
        #2 rst_big = 1'b0;
        k_big = 0;
        #1 cmp_big();
    endtask

    task automatic async_reset_sml();
        #2 rst_sml = 1'b0;
        k_sml = 0;
        #1 cmp_sml();
    endtask

    initial begin
        int frames;
        int run_len;
        clear_stats();

        // Reset held across a few edges, then released between edges
        repeat (3) tick();
        #2;
        rst_big = 1'b1;
        rst_sml = 1'b1;
        clear_stats();
        tick();
        check("first_sx", 32'(big_if.sx), 32'd0);
        check("first_sy", 32'(big_if.sy), 32'd0);
        check("first_de", 32'(big_if.de), 32'd1);

        // Rest of line 0 and the wrap into line 1
        repeat (800) tick();
        check("line_de_cycles", 32'(de_line), 32'(B_HRES));
        check("line_hsync_cycles", 32'(hs_line), 32'(B_HSW));
        check("wrap_sx", 32'(big_if.sx), 32'd0);
        check("wrap_sy", 32'(big_if.sy), 32'd1);

        // Mid-line asynchronous reset of the full-size raster at (300, 2)
        while (k_big < 2 * 800 + 301) tick();
        check("pre_rst_sx", 32'(big_if.sx), 32'd300);
        async_reset_big();

        // Three whole frames on the shrunken raster from a fresh reset
        async_reset_sml();
        repeat (2) tick();
        #2;
        rst_big = 1'b1;
        rst_sml = 1'b1;
        clear_stats();
        frames = 3;
        repeat (frames * S_FRAME) tick();
        check("vsync_rises", 32'(vs_rise), 32'(frames));
        check("vsync_low_cycles", 32'(vs_low), 32'(frames * S_VSW * S_HTOT));
        check("hsync_in_vsync", 32'(hs_in_vs), 32'(frames * S_VSW));
        check("de_in_vblank", 32'(de_vblank), 32'd0);
        tick();
        check("frame_wrap_sx", 32'(sml_if.sx), 32'd0);
        check("frame_wrap_sy", 32'(sml_if.sy), 32'd0);

        // Scaled mid-line reset at (30, 10), then random-length runs with random resets
        while (((k_sml - 1) % S_FRAME) != 10 * S_HTOT + 30) tick();
        async_reset_sml();
        for (int i = 0; i < 4; i++) begin
            repeat (2) tick();
            #2 rst_sml = 1'b1;
            run_len = int'($urandom_range(1, 3000));
            repeat (run_len) tick();
            async_reset_sml();
        end
        repeat (2) tick();
        #2 rst_sml = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
